// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
// Shared constants and helpers for the round-robin stream multiplexer.
//   N_MAX       : largest supported channel count
//   W_MIN       : smallest supported data width
//   clog2_min1  : index width for a channel count, never below 1 bit
//   chan_lsb    : LSB position of channel k inside a packed N*W data bus
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int N_MAX = 16;
    localparam int W_MIN = 1;

    // Index width for a given channel count, clamped to at least one bit.
    function automatic int clog2_min1(input int value);
        if (value <= 2) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

    // Bit offset of channel 'chan' in a bus of 'width'-bit slices.
    function automatic int chan_lsb(input int chan, input int width);
        return chan * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   req_i          : per-channel request
//   advance_i      : a beat from the granted channel was accepted this cycle
//   lock_i         : keep the pointer on the granted channel instead of
//                    moving past it (used while a packet holds the grant)
//   grant_o        : one-hot grant (all-zero when nothing requests)
//   grant_idx_o    : binary index of the granted channel
// -----------------------------------------------------------------------------
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          advance_i,
    input  logic          lock_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Search ptr, ptr+1, ... wrapping modulo N; first requester wins.
    always_comb begin
        int  cand;
        logic found;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end else begin
                cand = cand;
            end
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = IW'(cand);
            end else begin
                found = found;
            end
        end
    end

    // Next pointer: stay on the winner while locked, otherwise step past it.
    always_comb begin
        if (!advance_i) begin
            ptr_d = ptr_q;
        end else if (lock_i) begin
            ptr_d = grant_idx_o;
        end else if (grant_idx_o == IW'(N - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = grant_idx_o + IW'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
// N:1 valid/ready stream multiplexer with round-robin arbitration and a
// one-deep registered output stage (full throughput, no bubble on refill).
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   in_data_i     : packed channel data, channel k at [k*W +: W]
//   in_valid_i    : per-channel beat valid
//   in_last_i     : per-channel end-of-packet flag
//   in_ready_o    : per-channel accept (at most one bit high)
//   out_data_o    : registered data
//   out_valid_o   : output register holds a beat
//   out_last_o    : registered in_last of the accepted beat
//   out_sel_o     : channel that supplied the current output beat
//   out_ready_i   : downstream accept
// Optional feature macro: STREAM_MUX_LOCK_EN -- when defined, the grant is held
// on a channel from its first non-last beat until its last beat is accepted.
// -----------------------------------------------------------------------------
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = clog2_min1(N)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [N*W-1:0] in_data_i,
    input  logic [N-1:0]   in_valid_i,
    input  logic [N-1:0]   in_last_i,
    output logic [N-1:0]   in_ready_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_valid_o,
    output logic           out_last_o,
    output logic [SW-1:0]  out_sel_o,
    input  logic           out_ready_i
);

    if (N < 2 || N > N_MAX || W < W_MIN) begin : g_bad_param
        $error("stream_mux_rr: N or W outside the supported range");
    end

    logic [W-1:0]  out_data_q;
    logic          out_valid_q;
    logic          out_last_q;
    logic [SW-1:0] out_sel_q;

    logic          load_s;
    logic          accept_s;
    logic          lock_hold_s;
    logic [N-1:0]  req_s;
    logic [N-1:0]  grant_s;
    logic [N-1:0]  in_ready_s;
    logic [SW-1:0] grant_idx_s;
    logic [W-1:0]  sel_data_s;
    logic          sel_last_s;

    assign load_s   = !out_valid_q || out_ready_i;
    assign accept_s = |(in_valid_i & in_ready_s);

    // Ready only for the granted channel, only when the output can load,
    // and never while reset is asserted.
    always_comb begin
        if (rst_i || !load_s) begin
            in_ready_s = '0;
        end else begin
            in_ready_s = grant_s;
        end
    end

    // Select the granted channel's data and last flag.
    always_comb begin
        sel_data_s = in_data_i[chan_lsb(int'(grant_idx_s), W) +: W];
        sel_last_s = in_last_i[grant_idx_s];
    end

`ifdef STREAM_MUX_LOCK_EN
    logic lock_q;
    logic lock_d;

    // A non-last beat opens a packet lock; the last beat closes it.
    always_comb begin
        if (accept_s) begin
            lock_d = !sel_last_s;
        end else begin
            lock_d = lock_q;
        end
    end

    // While locked only the channel that owns the packet may request; the
    // last output beat always came from that channel, so out_sel_q names it.
    always_comb begin
        if (lock_q) begin
            req_s = in_valid_i & ({{(N-1){1'b0}}, 1'b1} << out_sel_q);
        end else begin
            req_s = in_valid_i;
        end
    end

    // Packet lock register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign lock_hold_s = lock_d;
`else
    assign req_s       = in_valid_i;
    assign lock_hold_s = 1'b0;
`endif

    rr_arbiter #(
        .N  (N),
        .IW (SW)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_s),
        .advance_i   (accept_s),
        .lock_i      (lock_hold_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Output register: refill on accept, empty when loadable but idle,
    // otherwise hold under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (load_s) begin
            if (accept_s) begin
                out_data_q  <= sel_data_s;
                out_last_q  <= sel_last_s;
                out_sel_q   <= grant_idx_s;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign in_ready_o  = in_ready_s;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_sel_o   = out_sel_q;

endmodule
